// File: rtl/kgp_io_port.sv
// kgp_io_port -- push-button / switch-bank input port and display output port.
//
// A debounced press of `button` captures the 5-bit switch bank `array` into a
// hold register and marks it pending. The processor's input instruction
// raises `rd_req` and stalls until the port answers with a one-cycle
// `rd_valid` strobe.
//
// A press that lands while an earlier value is still unread overwrites that
// value and sets the overrun flag. The flag is reported in rd_data[31].
//
// Build option:
//   KGP_IO_DEBOUNCE_EN  defined   -> four-state debounce FSM with a 16-bit
//                                    stability counter. The press event fires
//                                    2 + DEBOUNCE_CYCLES cycles after a clean
//                                    rise.
//                       undefined -> no FSM. The press event is the rising
//                                    edge of the synchronized button, 3 cycles
//                                    after the rise. DEBOUNCE_CYCLES is
//                                    ignored.
//
// Handshake: rd_req is a level. A press value is consumed at the first rising
// edge where rd_req=1 and pending=1. rd_valid is high for exactly the next
// cycle, and rd_data is valid only while rd_valid=1 (zero otherwise).
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   button   in   raw push-button, high = pressed
//   array    in   raw 5-bit switch bank
//   rd_req   in   processor read request (level)
//   rd_valid out  one-cycle read strobe
//   rd_data  out  {overrun, 26'b0, hold} while rd_valid, else 0
//   wr_en    in   processor write strobe
//   wr_data  in   processor write value, low OUT_W bits used
//   out      out  registered display value
module kgp_io_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OUT_W           = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [4:0]       array,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    output logic [OUT_W-1:0] out
);

    // Two-flop synchronizers for the asynchronous inputs.
    logic       btn_m, btn_s;
    logic [4:0] arr_m, arr_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            arr_m <= 5'd0;
            arr_s <= 5'd0;
        end else begin
            btn_m <= button;
            btn_s <= btn_m;
            arr_m <= array;
            arr_s <= arr_m;
        end
    end

    logic press_evt;
    logic unused_ok;

`ifdef KGP_IO_DEBOUNCE_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

    state_t      state;
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_CHK;
                        cnt   <= 16'd1;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LIMIT) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL_CHK;
                        cnt   <= 16'd1;
                    end
                end
                REL_CHK: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (cnt == DB_LIMIT) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    // The press event is the PRESS_CHK -> HELD transition itself. It is
    // decoded from the registered state so that the hold register latches
    // arr_s on the same edge that the FSM enters HELD.
    assign press_evt = (state == PRESS_CHK) && btn_s && (cnt == DB_LIMIT);

    assign unused_ok = &{1'b0, wr_data[31:OUT_W]};
`else
    // Without debounce, the press event is a registered rising edge of
    // btn_s. This gives a 3-cycle latency from the raw rise to the capture.
    logic btn_d;
    logic evt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_d <= 1'b0;
            evt_r <= 1'b0;
        end else begin
            btn_d <= btn_s;
            evt_r <= btn_s & ~btn_d;
        end
    end

    assign press_evt = evt_r;

    assign unused_ok = &{1'b0, wr_data[31:OUT_W], (DEBOUNCE_CYCLES == 0)};
`endif

    // Capture and read handshake.
    logic [4:0] hold;
    logic       pending;
    logic       overrun;
    logic       consume;

    assign consume = rd_req & pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= 5'd0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 32'd0;
        end else begin
            rd_valid <= consume;
            // The right-hand side reads the old hold and overrun values, so a
            // consume that coincides with a press delivers the earlier capture.
            rd_data  <= consume ? {overrun, 26'd0, hold} : 32'd0;

            if (press_evt) begin
                hold <= arr_s;
            end

            // A coincident press keeps pending set, now holding the new value.
            if (press_evt) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end

            // Overrun means that a value was lost. A coincident consume saves
            // the old value, so it clears the flag rather than setting it.
            if (consume) begin
                overrun <= 1'b0;
            end else if (press_evt && pending) begin
                overrun <= 1'b1;
            end
        end
    end

    // Display output register, independent of the read path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (wr_en) begin
            out <= wr_data[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_kgp_io_port.sv
// Testbench for kgp_io_port (DEBOUNCE_CYCLES=4, OUT_W=13).
// Expectations follow the KGP_IO_DEBOUNCE_EN setting seen by this file.
`timescale 1ns/1ps
module tb_kgp_io_port;
  localparam int OUT_W = 13;

`ifdef KGP_IO_DEBOUNCE_EN
  localparam int LAT_MIN   = 6;
  localparam int LAT_MAX   = 8;
  localparam int EVT_WAIT  = 6;
  localparam logic [31:0] BOUNCE_EXP = 32'h0000_0005;
`else
  localparam int LAT_MIN   = 3;
  localparam int LAT_MAX   = 5;
  localparam int EVT_WAIT  = 3;
  localparam logic [31:0] BOUNCE_EXP = 32'h8000_0005;
`endif

  logic             clk;
  logic             rst;
  logic             button;
  logic [4:0]       array;
  logic             rd_req;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic [OUT_W-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  logic [31:0] exp_q[$];

  kgp_io_port #(.DEBOUNCE_CYCLES(4), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .button(button), .array(array),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .out(out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every rd_valid pops one expected value; rd_data must be 0 otherwise
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (rd_valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end else begin
        check("rd_data_idle_zero", rd_data, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic press(input logic [4:0] a, input int high);
    @(negedge clk);
    array  = a;
    button = 1'b1;
    repeat (high) @(negedge clk);
    button = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int cycles);
    cycles = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic read_expect(input logic [31:0] e);
    int c;
    exp_q.push_back(e);
    rd_req = 1'b1;
    wait_valid(40, c);
    rd_req = 1'b0;
    check("read_completed", 32'(c > 0), 32'd1);
  endtask

  task automatic stall_check(input string tag);
    int v0;
    v0 = n_valid;
    @(negedge clk);
    rd_req = 1'b1;
    repeat (20) @(negedge clk);
    rd_req = 1'b0;
    check(tag, 32'(n_valid - v0), 32'd0);
  endtask

  task automatic write_check(input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    check("out_write", 32'(out), d & 32'h0000_1FFF);
  endtask

  initial begin
    int c;
    logic [31:0] r;
    rst = 1'b1; button = 1'b0; array = 5'd0; rd_req = 1'b0;
    wr_en = 1'b0; wr_data = 32'd0;
    #1;
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_out", 32'(out), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // output path
    write_check(32'hFFFF_1ABC);
    @(negedge clk);
    wr_data = 32'h0000_0123;
    @(negedge clk);
    check("out_hold_no_wr_en", 32'(out), 32'h0000_1ABC);
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(32'h7FFF_FFFF, 0);
      write_check(r);
    end

    // clean press, rd_req held from the button rise
    @(negedge clk);
    array  = 5'd3;
    button = 1'b1;
    rd_req = 1'b1;
    exp_q.push_back(32'h0000_0003);
    wait_valid(20, c);
    rd_req = 1'b0;
    check("clean_press_latency", 32'(c >= LAT_MIN && c <= LAT_MAX), 32'd1);
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (12) @(negedge clk);
    stall_check("clean_single_valid");

    // bounce: high 2, low 1, high 10
    @(negedge clk);
    array  = 5'd5;
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    @(negedge clk);
    button = 1'b1;
    repeat (10) @(negedge clk);
    button = 1'b0;
    repeat (12) @(negedge clk);
    read_expect(BOUNCE_EXP);
    stall_check("bounce_single_valid");

    // overrun
    press(5'd3, 10);
    press(5'd1, 10);
    read_expect(32'h8000_0001);
    stall_check("overrun_then_stall");

    // coincidence of press event and consume
    press(5'd1, 10);
    exp_q.push_back(32'h0000_0001);
    @(negedge clk);
    array  = 5'd5;
    button = 1'b1;
    repeat (EVT_WAIT) @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    check("coinc_rd_valid", 32'(rd_valid), 32'd1);
    rd_req = 1'b0;
    repeat (6) @(negedge clk);
    button = 1'b0;
    repeat (12) @(negedge clk);
    read_expect(32'h0000_0005);
    stall_check("coinc_then_stall");

    // asynchronous reset during a read strobe, with pending data and out loaded
    press(5'd7, 10);
    write_check(32'h0000_0155);
    exp_q.push_back(32'h0000_0007);
    rd_req = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("async_rst_rd_data", rd_data, 32'd0);
    check("async_rst_out", 32'(out), 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stall_check("rst_discards_pending");

    // pending value discarded by a reset during the handshake (before rd_valid)
    press(5'd2, 10);
    rd_req = 1'b1;
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b0;
    stall_check("rst_mid_handshake_discard");

    // reset mid-debounce: a fresh full debounce is needed after release
    @(negedge clk);
    array  = 5'd6;
    button = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'h0000_0006);
    rd_req = 1'b1;
    wait_valid(20, c);
    rd_req = 1'b0;
    check("post_rst_full_debounce", 32'(c >= LAT_MIN && c <= LAT_MAX), 32'd1);
    repeat (4) @(negedge clk);
    button = 1'b0;
    repeat (12) @(negedge clk);

    // final report
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kgp_io_port.md
KGP_IO_PORT -- requirements
Module: kgp_io_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles required to accept a button level change (legal range 1..65535).
REQ-002 Parameter OUT_W, default 13, width of the output display register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 button  input  1  raw asynchronous push-button, high = pressed.
REQ-006 array  input  5  raw asynchronous switch bank, sampled at a press.
REQ-007 rd_req  input  1  processor input-instruction request, level, held until rd_valid.
REQ-008 rd_valid  output  1  one-cycle strobe, rd_data valid for processor register write.
REQ-009 rd_data  output  32  captured switch value plus status, stable while rd_valid is high.
REQ-010 wr_en  input  1  processor output-instruction strobe.
REQ-011 wr_data  input  32  processor output value; bits [OUT_W-1:0] used.
REQ-012 out  output  OUT_W  registered display value.

Function
REQ-013 button and array SHALL each pass through a two-flop synchronizer before any use; the synchronized signals are btn_s and arr_s.
REQ-014 Button FSM states SHALL be IDLE, PRESS_CHK, HELD, REL_CHK, with a 16-bit stability counter cnt.
REQ-015 IDLE: btn_s=1 -> PRESS_CHK with cnt=1; else stay.
REQ-016 PRESS_CHK: btn_s=0 -> IDLE; btn_s=1 and cnt=DEBOUNCE_CYCLES -> HELD; else cnt+1.
REQ-017 HELD: btn_s=0 -> REL_CHK with cnt=1; else stay.
REQ-018 REL_CHK: btn_s=1 -> HELD; btn_s=0 and cnt=DEBOUNCE_CYCLES -> IDLE; else cnt+1.
REQ-019 The PRESS_CHK->HELD transition SHALL emit a one-cycle press event; on that edge arr_s SHALL be latched into a 5-bit hold register and pending SHALL set.
REQ-020 If a press event occurs while pending=1 and no consume occurs that cycle, hold SHALL be overwritten and overrun SHALL set.
REQ-021 Consume: rd_req=1 and pending=1 at a rising edge -> next cycle rd_valid=1 for exactly one cycle, rd_data={overrun,26'b0,hold}, then pending and overrun clear.
REQ-022 Simultaneous consume and press event: the old hold value SHALL be delivered, and pending SHALL remain set with the new value latched; overrun SHALL NOT set.
REQ-023 rd_req=1 with pending=0: no response; the processor stalls until a press arrives; rd_req deassertion before rd_valid SHALL leave pending unchanged.
REQ-024 rd_data SHALL be zero whenever rd_valid=0.
REQ-025 wr_en=1 at a rising edge SHALL load out<=wr_data[OUT_W-1:0] with one-cycle latency; wr_en is independent of the read path.
REQ-026 Press-to-event latency from a clean button rise SHALL be 2 (sync) + DEBOUNCE_CYCLES cycles.

Reset
REQ-027 rst=1 SHALL immediately force: FSM=IDLE, cnt=0, synchronizers=0, hold=0, pending=0, overrun=0, rd_valid=0, rd_data=0, out=0.
REQ-028 rst asserted mid-debounce or mid-handshake SHALL discard pending data; after release a press requires a full new debounce.

Configuration
REQ-029 Macro KGP_IO_DEBOUNCE_EN: when defined, REQ-014..REQ-018 apply.
REQ-030 Without KGP_IO_DEBOUNCE_EN: the FSM and counter are removed, and the press event equals the btn_s rising edge (latency 3 cycles); DEBOUNCE_CYCLES is ignored.

Verification (DEBOUNCE_CYCLES=4, macro defined)
REQ-031 Reset: rst pulse mid-simulation -> all outputs 0 asynchronously, before the next clk edge.
REQ-032 Clean press with array=3, rd_req held high -> exactly one rd_valid, rd_data=0x00000003, 6-8 cycles after the button rise.
REQ-033 Bounce: button high 2 cycles, low 1 cycle, high 10 cycles with array=5 -> exactly one press event, rd_data=0x00000005.
REQ-034 Overrun: press array=3, release, press array=1, then rd_req -> rd_data=0x80000001; a second rd_req stalls with no rd_valid.
REQ-035 Coincidence: press event in the same cycle as a consume of pending value 1 with new array=5 -> rd_data=0x00000001, a following rd_req returns 0x00000005 with no overrun.
REQ-036 Output path: wr_en with wr_data=0xFFFF1ABC -> out=13'h1ABC next cycle; no change with wr_en=0.
